// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates entries at tail, marks them completed from writeback,
// retires from head in program order. Optional operand bypass search under ROB_BYPASS_EN.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = $clog2(ROB_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [31:0]      alloc_pc_i,
    input  logic [31:0]      alloc_instr_i,
    input  logic [4:0]       alloc_rd_i,
    input  logic             alloc_we_i,
    input  logic             alloc_store_i,
    output logic [IDX_W-1:0] alloc_idx_o,
    input  logic             wb_valid_i,
    input  logic [IDX_W-1:0] wb_idx_i,
    input  logic [31:0]      wb_result_i,
    input  logic             wb_branch_taken_i,
    input  logic [31:0]      wb_new_pc_i,
    output logic             commit_valid_o,
    output logic [IDX_W-1:0] commit_idx_o,
    output logic [31:0]      commit_pc_o,
    output logic [4:0]       commit_rd_o,
    output logic             commit_we_o,
    output logic             commit_store_o,
    output logic [31:0]      commit_result_o,
    output logic             flush_o,
    output logic [31:0]      flush_pc_o,
    output logic [IDX_W:0]   count_o,
    output logic             empty_o,
    input  logic [4:0]       byp_rs1_i,
    input  logic [4:0]       byp_rs2_i,
    output logic             byp_rs1_hit_o,
    output logic             byp_rs2_hit_o,
    output logic [31:0]      byp_rs1_data_o,
    output logic [31:0]      byp_rs2_data_o
);
    typedef logic [IDX_W-1:0] rob_idx_t;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] valid_q;
    logic [ROB_SIZE-1:0] done_q;
    logic [ROB_SIZE-1:0] we_q;
    logic [ROB_SIZE-1:0] store_q;
    logic [ROB_SIZE-1:0] taken_q;
    logic [31:0]         pc_q     [ROB_SIZE];
    logic [31:0]         instr_q  [ROB_SIZE];
    logic [31:0]         result_q [ROB_SIZE];
    logic [31:0]         new_pc_q [ROB_SIZE];
    logic [4:0]          rd_q     [ROB_SIZE];
    rob_idx_t            head_q;
    rob_idx_t            tail_q;
    logic [IDX_W:0]      count_q;

    logic alloc_fire;
    logic wb_hit;
    logic unused_instr;

    // Reset in progress suppresses retirement so in-flight work is dropped, never committed.
    assign commit_valid_o = valid_q[head_q] && done_q[head_q] && !rst_i;
    assign flush_o        = commit_valid_o && taken_q[head_q];
    assign alloc_ready_o  = (count_q < FULL_COUNT) && !flush_o;
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;
    assign wb_hit         = wb_valid_i && valid_q[wb_idx_i];

    assign alloc_idx_o     = tail_q;
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0);
    assign commit_idx_o    = head_q;
    assign commit_pc_o     = commit_valid_o ? pc_q[head_q] : '0;
    assign commit_rd_o     = commit_valid_o ? rd_q[head_q] : '0;
    assign commit_we_o     = commit_valid_o && we_q[head_q] && (rd_q[head_q] != 5'd0);
    assign commit_store_o  = commit_valid_o && store_q[head_q];
    assign commit_result_o = commit_valid_o ? result_q[head_q] : '0;
    assign flush_pc_o      = flush_o ? new_pc_q[head_q] : '0;
    assign unused_instr    = ^instr_q[head_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_o) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            if (wb_hit)
                done_q[wb_idx_i] <= 1'b1;
            if (commit_valid_o) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_valid_o);
        end
    end

    // Payload storage carries no reset; validity alone qualifies every read.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            pc_q[tail_q]    <= alloc_pc_i;
            instr_q[tail_q] <= alloc_instr_i;
            rd_q[tail_q]    <= alloc_rd_i;
            we_q[tail_q]    <= alloc_we_i;
            store_q[tail_q] <= alloc_store_i;
        end
        if (wb_hit) begin
            result_q[wb_idx_i] <= wb_result_i;
            new_pc_q[wb_idx_i] <= wb_new_pc_i;
            taken_q[wb_idx_i]  <= wb_branch_taken_i;
        end
    end

`ifdef ROB_BYPASS_EN
    rob_idx_t byp_k;

    // Walk oldest to youngest from head so the last match found is the youngest producer.
    always_comb begin
        byp_k          = head_q;
        byp_rs1_hit_o  = 1'b0;
        byp_rs2_hit_o  = 1'b0;
        byp_rs1_data_o = '0;
        byp_rs2_data_o = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            byp_k = head_q + rob_idx_t'(i);
            if (valid_q[byp_k] && done_q[byp_k] && we_q[byp_k] && rd_q[byp_k] != 5'd0) begin
                if (rd_q[byp_k] == byp_rs1_i) begin
                    byp_rs1_hit_o  = 1'b1;
                    byp_rs1_data_o = result_q[byp_k];
                end
                if (rd_q[byp_k] == byp_rs2_i) begin
                    byp_rs2_hit_o  = 1'b1;
                    byp_rs2_data_o = result_q[byp_k];
                end
            end
        end
    end
`else
    logic unused_byp;

    assign unused_byp     = ^{byp_rs1_i, byp_rs2_i};
    assign byp_rs1_hit_o  = 1'b0;
    assign byp_rs2_hit_o  = 1'b0;
    assign byp_rs1_data_o = '0;
    assign byp_rs2_data_o = '0;
`endif

    wb_alloc_collision: assert property (@(posedge clk_i) disable iff (rst_i)
        !(alloc_fire && wb_valid_i && wb_idx_i == tail_q));

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; bypass expectations follow ROB_BYPASS_EN.
module tb_reorder_buffer;
    localparam int ROB_SIZE = 16;
    localparam int IDX_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid, alloc_ready;
    logic [31:0]      alloc_pc, alloc_instr;
    logic [4:0]       alloc_rd;
    logic             alloc_we, alloc_store;
    logic [IDX_W-1:0] alloc_idx;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_result, wb_new_pc;
    logic             wb_taken;
    logic             commit_valid;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_pc, commit_result;
    logic [4:0]       commit_rd;
    logic             commit_we, commit_store;
    logic             flush;
    logic [31:0]      flush_pc;
    logic [IDX_W:0]   count;
    logic             empty;
    logic [4:0]       byp_rs1, byp_rs2;
    logic             byp_rs1_hit, byp_rs2_hit;
    logic [31:0]      byp_rs1_data, byp_rs2_data;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_pc_i(alloc_pc), .alloc_instr_i(alloc_instr), .alloc_rd_i(alloc_rd),
        .alloc_we_i(alloc_we), .alloc_store_i(alloc_store), .alloc_idx_o(alloc_idx),
        .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_result_i(wb_result),
        .wb_branch_taken_i(wb_taken), .wb_new_pc_i(wb_new_pc),
        .commit_valid_o(commit_valid), .commit_idx_o(commit_idx), .commit_pc_o(commit_pc),
        .commit_rd_o(commit_rd), .commit_we_o(commit_we), .commit_store_o(commit_store),
        .commit_result_o(commit_result), .flush_o(flush), .flush_pc_o(flush_pc),
        .count_o(count), .empty_o(empty),
        .byp_rs1_i(byp_rs1), .byp_rs2_i(byp_rs2),
        .byp_rs1_hit_o(byp_rs1_hit), .byp_rs2_hit_o(byp_rs2_hit),
        .byp_rs1_data_o(byp_rs1_data), .byp_rs2_data_o(byp_rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_pc = '0; alloc_instr = '0; alloc_rd = '0;
        alloc_we = 1'b0; alloc_store = 1'b0;
        wb_valid = 1'b0; wb_idx = '0; wb_result = '0; wb_taken = 1'b0; wb_new_pc = '0;
        byp_rs1 = '0; byp_rs2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                            input logic st);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_instr = 32'h0000_0013;
        alloc_rd = rd; alloc_we = we; alloc_store = st;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_wb(input logic [IDX_W-1:0] idx, input logic [31:0] res,
                          input logic taken, input logic [31:0] npc);
        wb_valid = 1'b1; wb_idx = idx; wb_result = res; wb_taken = taken; wb_new_pc = npc;
    endtask

    task automatic do_wb(input logic [IDX_W-1:0] idx, input logic [31:0] res);
        set_wb(idx, res, 1'b0, 32'h0);
        tick();
        wb_valid = 1'b0;
    endtask

    logic [IDX_W-1:0] wrap_seq [4];

    initial begin
        wrap_seq[0] = 4'd14; wrap_seq[1] = 4'd15; wrap_seq[2] = 4'd0; wrap_seq[3] = 4'd1;
        do_reset();

        // Reset state
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_commit_pc", commit_pc, 32'd0);

        // Three allocations completed out of order 2, 0, 1
        for (int i = 0; i < 3; i++) begin
            check("ooo_alloc_idx", 32'(alloc_idx), 32'(i));
            do_alloc(32'(4 * i), 5'(i + 1), 1'b1, 1'b0);
        end
        check("ooo_count3", 32'(count), 32'd3);
        do_wb(4'd2, 32'h22);
        check("ooo_no_commit_head_pending", 32'(commit_valid), 32'd0);
        do_wb(4'd0, 32'h10);
        set_wb(4'd1, 32'h11, 1'b0, 32'h0);
        check("ooo_commit0_valid", 32'(commit_valid), 32'd1);
        check("ooo_commit0_idx", 32'(commit_idx), 32'd0);
        check("ooo_commit0_result", commit_result, 32'h10);
        tick();
        wb_valid = 1'b0;
        check("ooo_commit1_idx", 32'(commit_idx), 32'd1);
        check("ooo_commit1_pc", commit_pc, 32'h4);
        check("ooo_commit1_result", commit_result, 32'h11);
        tick();
        check("ooo_commit2_valid", 32'(commit_valid), 32'd1);
        check("ooo_commit2_pc", commit_pc, 32'h8);
        check("ooo_commit2_rd", 32'(commit_rd), 32'd3);
        check("ooo_commit2_we", 32'(commit_we), 32'd1);
        tick();
        check("ooo_done_empty", 32'(empty), 32'd1);
        check("ooo_done_commit_valid", 32'(commit_valid), 32'd0);

        // Fill to capacity
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++)
            do_alloc(32'h1000 + 32'(4 * i), 5'((i % 31) + 1), 1'b1, 1'b0);
        check("full_ready", 32'(alloc_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        check("full_empty", 32'(empty), 32'd0);
        do_wb(4'd0, 32'hAA);
        check("full_commit_valid", 32'(commit_valid), 32'd1);
        check("full_ready_during_commit", 32'(alloc_ready), 32'd0);
        tick();
        check("full_after_count", 32'(count), 32'd15);
        check("full_after_ready", 32'(alloc_ready), 32'd1);

        // Pointer wrap: move head to 14, then allocate across the end
        do_reset();
        for (int i = 0; i < 14; i++)
            do_alloc(32'(4 * i), 5'd1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++)
            do_wb(4'(i), 32'(i));
        tick();
        check("wrap_pre_count", 32'(count), 32'd0);
        check("wrap_pre_tail", 32'(alloc_idx), 32'd14);
        for (int k = 0; k < 4; k++) begin
            check("wrap_alloc_idx", 32'(alloc_idx), 32'(wrap_seq[k]));
            do_alloc(32'h3000 + 32'(4 * k), 5'd2, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            set_wb(wrap_seq[k], 32'h500 + 32'(k), 1'b0, 32'h0);
            if (k > 0) check("wrap_commit_idx", 32'(commit_idx), 32'(wrap_seq[k-1]));
            tick();
            wb_valid = 1'b0;
        end
        check("wrap_commit_last_idx", 32'(commit_idx), 32'd1);
        check("wrap_commit_last_result", commit_result, 32'h503);
        tick();
        check("wrap_done_empty", 32'(empty), 32'd1);

        // Taken branch at entry 1 squashes completed entries 2..4
        do_reset();
        for (int i = 0; i < 5; i++)
            do_alloc(32'h200 + 32'(4 * i), 5'd3, 1'b1, 1'b0);
        do_wb(4'd2, 32'h2);
        do_wb(4'd3, 32'h3);
        do_wb(4'd4, 32'h4);
        do_wb(4'd0, 32'h0);
        set_wb(4'd1, 32'h1, 1'b1, 32'h100);
        check("br_commit0_idx", 32'(commit_idx), 32'd0);
        check("br_commit0_noflush", 32'(flush), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("br_commit1_valid", 32'(commit_valid), 32'd1);
        check("br_commit1_idx", 32'(commit_idx), 32'd1);
        check("br_flush", 32'(flush), 32'd1);
        check("br_flush_pc", flush_pc, 32'h100);
        check("br_ready_during_flush", 32'(alloc_ready), 32'd0);
        tick();
        check("br_after_count", 32'(count), 32'd0);
        check("br_after_empty", 32'(empty), 32'd1);
        check("br_after_commit_valid", 32'(commit_valid), 32'd0);
        check("br_after_tail", 32'(alloc_idx), 32'd0);
        tick();
        check("br_squashed_stay_gone", 32'(commit_valid), 32'd0);

        // rd 0 write is masked; store flag passes through
        do_reset();
        do_alloc(32'h40, 5'd0, 1'b1, 1'b1);
        do_wb(4'd0, 32'hDEAD);
        check("rd0_commit_valid", 32'(commit_valid), 32'd1);
        check("rd0_commit_we", 32'(commit_we), 32'd0);
        check("rd0_commit_store", 32'(commit_store), 32'd1);
        tick();

        // Completion of an unallocated entry is dropped
        do_reset();
        do_wb(4'd0, 32'h77);
        do_alloc(32'h80, 5'd4, 1'b1, 1'b0);
        check("stale_wb_ignored", 32'(commit_valid), 32'd0);

        // Simultaneous alloc and commit at count 5
        do_reset();
        for (int i = 0; i < 5; i++)
            do_alloc(32'(4 * i), 5'd6, 1'b1, 1'b0);
        do_wb(4'd0, 32'h9);
        alloc_valid = 1'b1; alloc_pc = 32'h90; alloc_rd = 5'd7; alloc_we = 1'b1;
        check("both_alloc_idx", 32'(alloc_idx), 32'd5);
        check("both_commit_valid", 32'(commit_valid), 32'd1);
        tick();
        alloc_valid = 1'b0;
        check("both_count", 32'(count), 32'd5);

        // Reset while a commit is pending
        do_reset();
        do_alloc(32'h10, 5'd1, 1'b1, 1'b0);
        do_alloc(32'h14, 5'd2, 1'b1, 1'b0);
        do_wb(4'd0, 32'h1);
        check("midrst_pending", 32'(commit_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_no_commit", 32'(commit_valid), 32'd0);
        check("midrst_no_flush", 32'(flush), 32'd0);
        tick();
        rst = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);

        // Bypass: two producers of x5 behind an incomplete head
        do_reset();
        do_alloc(32'h0, 5'd1, 1'b1, 1'b0);
        do_alloc(32'h4, 5'd5, 1'b1, 1'b0);
        do_alloc(32'h8, 5'd5, 1'b1, 1'b0);
        do_wb(4'd1, 32'h11);
        do_wb(4'd2, 32'h22);
        byp_rs1 = 5'd5;
        byp_rs2 = 5'd0;
        #1;
`ifdef ROB_BYPASS_EN
        check("byp_rs1_hit", 32'(byp_rs1_hit), 32'd1);
        check("byp_rs1_data", byp_rs1_data, 32'h22);
`else
        check("byp_rs1_hit", 32'(byp_rs1_hit), 32'd0);
        check("byp_rs1_data", byp_rs1_data, 32'h0);
`endif
        check("byp_rs2_hit", 32'(byp_rs2_hit), 32'd0);
        check("byp_rs2_data", byp_rs2_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
